muldiv_controller: RTL and testbench

//   Sequential front/back-end for the combinational multiplier_divider array.
//   - Accepts one operation request over a valid/ready handshake.
//   - Registers the operands onto the array inputs and waits SETTLE_CYCLES for the array to settle.
//   - Captures Result/Remainder and returns them over a valid/ready response handshake.
//   - Detects divide-by-zero and answers without consulting the array.

---
 rtl/muldiv_pkg.sv | 14 +
 rtl/muldiv_controller.sv | 104 ++++++++++
 tb/tb_muldiv_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiplier/divider controller.
// This file holds the FSM state type and the default operand widths.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned DEF_DEVIDENT_LENGTH = 10;
  localparam int unsigned DEF_DIVISOR_LENGTH  = 5;

endpackage

// File: rtl/muldiv_controller.sv
// Sequential request/response wrapper around the combinational multiplier_divider array.
// It registers the operands, waits for the array to settle, captures the result, and handles divide-by-zero itself.
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int unsigned DEVIDENT_LENGTH = DEF_DEVIDENT_LENGTH,
  parameter int unsigned DIVISOR_LENGTH  = DEF_DIVISOR_LENGTH,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic                       CLK,
  input  logic                       RST_n,
  input  logic                       Req_Valid,
  output logic                       Req_Ready,
  input  logic [DEVIDENT_LENGTH-1:0] Req_OperA,
  input  logic [DIVISOR_LENGTH-1:0]  Req_OperB,
  input  logic [DIVISOR_LENGTH-1:0]  Req_OperD,
  input  logic                       Req_Div_nMul,
  output logic [DEVIDENT_LENGTH-1:0] OperA,
  output logic [DIVISOR_LENGTH-1:0]  OperB,
  output logic [DIVISOR_LENGTH-1:0]  OperD,
  output logic                       Div_nMul,
  input  logic [DEVIDENT_LENGTH-1:0] Result,
  input  logic [DIVISOR_LENGTH-1:0]  Remainder,
  output logic                       Rsp_Valid,
  input  logic                       Rsp_Ready,
  output logic [DEVIDENT_LENGTH-1:0] Rsp_Result,
  output logic [DIVISOR_LENGTH-1:0]  Rsp_Remainder,
  output logic                       Rsp_DivZero,
  output logic                       Busy
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             divZeroPend;
  logic             accept;

  assign Req_Ready = (state == IDLE) | ((state == RESP) & Rsp_Ready);
  assign accept    = Req_Valid & Req_Ready;
  assign Rsp_Valid = (state == RESP);
  assign Busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state         <= IDLE;
      count         <= '0;
      divZeroPend   <= 1'b0;
      OperA         <= '0;
      OperB         <= '0;
      OperD         <= '0;
      Div_nMul      <= 1'b0;
      Rsp_Result    <= '0;
      Rsp_Remainder <= '0;
      Rsp_DivZero   <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            Div_nMul <= Req_Div_nMul;
            OperD    <= Req_OperD;
            if (Req_Div_nMul) begin
              OperA <= Req_OperA;
              OperB <= '0;
            end else begin
              OperA <= '0;
              OperB <= Req_OperB;
            end
            // Divide-by-zero spends one cycle in SETTLE so its answer appears after the next edge.
            state <= SETTLE;
            if (Req_Div_nMul && (Req_OperD == '0)) begin
              divZeroPend <= 1'b1;
              count       <= '0;
            end else begin
              divZeroPend <= 1'b0;
              count       <= CNT_LOAD;
            end
          end else if ((state == RESP) && Rsp_Ready) begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (count == '0) begin
            state <= RESP;
            if (divZeroPend) begin
              Rsp_Result    <= '1;
              Rsp_Remainder <= '0;
              Rsp_DivZero   <= 1'b1;
            end else begin
              Rsp_Result    <= Result;
              Rsp_Remainder <= Div_nMul ? Remainder : '0;
              Rsp_DivZero   <= 1'b0;
            end
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller, with a behavioural stand-in for the combinational array.
// The expected values are hand-computed constants.
module tb_muldiv_controller;

  localparam int unsigned DL = 10;
  localparam int unsigned VL = 5;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          Req_Valid = 1'b0;
  logic          Req_Ready;
  logic [DL-1:0] Req_OperA = '0;
  logic [VL-1:0] Req_OperB = '0;
  logic [VL-1:0] Req_OperD = '0;
  logic          Req_Div_nMul = 1'b0;
  logic [DL-1:0] OperA;
  logic [VL-1:0] OperB;
  logic [VL-1:0] OperD;
  logic          Div_nMul;
  logic [DL-1:0] Result;
  logic [VL-1:0] Remainder;
  logic          Rsp_Valid;
  logic          Rsp_Ready = 1'b0;
  logic [DL-1:0] Rsp_Result;
  logic [VL-1:0] Rsp_Remainder;
  logic          Rsp_DivZero;
  logic          Busy;

  int assertCount = 0;
  int failCount   = 0;

  always #5 CLK = ~CLK;

  muldiv_controller #(
    .DEVIDENT_LENGTH(DL),
    .DIVISOR_LENGTH (VL),
    .SETTLE_CYCLES  (2)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .Req_Valid    (Req_Valid),
    .Req_Ready    (Req_Ready),
    .Req_OperA    (Req_OperA),
    .Req_OperB    (Req_OperB),
    .Req_OperD    (Req_OperD),
    .Req_Div_nMul (Req_Div_nMul),
    .OperA        (OperA),
    .OperB        (OperB),
    .OperD        (OperD),
    .Div_nMul     (Div_nMul),
    .Result       (Result),
    .Remainder    (Remainder),
    .Rsp_Valid    (Rsp_Valid),
    .Rsp_Ready    (Rsp_Ready),
    .Rsp_Result   (Rsp_Result),
    .Rsp_Remainder(Rsp_Remainder),
    .Rsp_DivZero  (Rsp_DivZero),
    .Busy         (Busy)
  );

  // Stand-in for the multiplier_divider array sitting beside the controller.
  always_comb begin
    Result    = '0;
    Remainder = '0;
    if (Div_nMul) begin
      if (OperD != '0) begin
        Result    = OperA / DL'(OperD);
        Remainder = VL'(OperA % DL'(OperD));
      end
    end else begin
      Result = DL'(OperB) * DL'(OperD);
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic div, input logic [DL-1:0] a, input logic [VL-1:0] b,
                       input logic [VL-1:0] d);
    Req_Valid    = 1'b1;
    Req_Div_nMul = div;
    Req_OperA    = a;
    Req_OperB    = b;
    Req_OperD    = d;
    tick();
    Req_Valid = 1'b0;
  endtask

  task automatic waitRsp(output int n);
    n = 0;
    while (!Rsp_Valid && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic retire();
    Rsp_Ready = 1'b1;
    tick();
    Rsp_Ready = 1'b0;
    checkVal("retire_valid", 32'(Rsp_Valid), 0);
    checkVal("retire_busy", 32'(Busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;

    // 1. reset with a request pending
    Req_Valid = 1'b1; Req_Div_nMul = 1'b1; Req_OperA = 10'd100; Req_OperD = 5'd3;
    repeat (3) tick();
    checkVal("rst_operA", 32'(OperA), 0);
    checkVal("rst_operB", 32'(OperB), 0);
    checkVal("rst_operD", 32'(OperD), 0);
    checkVal("rst_divnmul", 32'(Div_nMul), 0);
    checkVal("rst_rspvalid", 32'(Rsp_Valid), 0);
    checkVal("rst_rspresult", 32'(Rsp_Result), 0);
    checkVal("rst_rsprem", 32'(Rsp_Remainder), 0);
    checkVal("rst_divzero", 32'(Rsp_DivZero), 0);
    checkVal("rst_busy", 32'(Busy), 0);
    Req_Valid = 1'b0;
    #2 RST_n = 1'b1;
    tick();
    checkVal("rel_reqready", 32'(Req_Ready), 1);
    checkVal("rel_busy", 32'(Busy), 0);

    // 2. divide 1023/15
    issue(1'b1, 10'd1023, 5'd0, 5'd15);
    checkVal("div_operA", 32'(OperA), 1023);
    checkVal("div_operB", 32'(OperB), 0);
    checkVal("div_busy", 32'(Busy), 1);
    checkVal("div_reqready", 32'(Req_Ready), 0);
    waitRsp(n);
    checkVal("div_latency", 32'(n), 2);
    checkVal("div_result", 32'(Rsp_Result), 68);
    checkVal("div_rem", 32'(Rsp_Remainder), 3);
    checkVal("div_dz", 32'(Rsp_DivZero), 0);
    retire();

    // 3. multiply 31*31
    issue(1'b0, 10'd555, 5'd31, 5'd31);
    checkVal("mul_operA", 32'(OperA), 0);
    checkVal("mul_operB", 32'(OperB), 31);
    checkVal("mul_mode", 32'(Div_nMul), 0);
    waitRsp(n);
    checkVal("mul_latency", 32'(n), 2);
    checkVal("mul_result", 32'(Rsp_Result), 961);
    checkVal("mul_rem", 32'(Rsp_Remainder), 0);
    retire();

    // 4. divide by zero
    issue(1'b1, 10'd25, 5'd9, 5'd0);
    checkVal("dz_operA", 32'(OperA), 25);
    checkVal("dz_operD", 32'(OperD), 0);
    waitRsp(n);
    checkVal("dz_latency", 32'(n), 1);
    checkVal("dz_flag", 32'(Rsp_DivZero), 1);
    checkVal("dz_result", 32'(Rsp_Result), 1023);
    checkVal("dz_rem", 32'(Rsp_Remainder), 0);
    retire();

    // divide 1000/31 with non-zero remainder
    issue(1'b1, 10'd1000, 5'd0, 5'd31);
    waitRsp(n);
    checkVal("div2_result", 32'(Rsp_Result), 32);
    checkVal("div2_rem", 32'(Rsp_Remainder), 8);
    checkVal("div2_dz", 32'(Rsp_DivZero), 0);
    retire();

    // 5. backpressure, then back-to-back request on the retiring edge
    issue(1'b1, 10'd21, 5'd0, 5'd7);
    waitRsp(n);
    Req_Valid = 1'b1; Req_Div_nMul = 1'b0; Req_OperB = 5'd12; Req_OperD = 5'd15;
    for (int i = 0; i < 5; i++) begin
      checkVal("hold_valid", 32'(Rsp_Valid), 1);
      checkVal("hold_result", 32'(Rsp_Result), 3);
      checkVal("hold_rem", 32'(Rsp_Remainder), 0);
      checkVal("hold_reqready", 32'(Req_Ready), 0);
      tick();
    end
    checkVal("hold_operA", 32'(OperA), 21);
    Rsp_Ready = 1'b1;
    #1 checkVal("b2b_reqready", 32'(Req_Ready), 1);
    tick();
    Req_Valid = 1'b0;
    Rsp_Ready = 1'b0;
    checkVal("b2b_valid_drop", 32'(Rsp_Valid), 0);
    checkVal("b2b_busy", 32'(Busy), 1);
    checkVal("b2b_operB", 32'(OperB), 12);
    checkVal("b2b_mode", 32'(Div_nMul), 0);
    waitRsp(n);
    checkVal("b2b_latency", 32'(n), 2);
    checkVal("b2b_result", 32'(Rsp_Result), 180);
    checkVal("b2b_rem", 32'(Rsp_Remainder), 0);
    retire();

    // 6. reset during SETTLE discards the operation
    issue(1'b1, 10'd28, 5'd0, 5'd7);
    checkVal("abort_busy", 32'(Busy), 1);
    #2 RST_n = 1'b0;
    #1;
    checkVal("abort_busy_rst", 32'(Busy), 0);
    checkVal("abort_valid_rst", 32'(Rsp_Valid), 0);
    checkVal("abort_operA_rst", 32'(OperA), 0);
    #3 RST_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Rsp_Valid) seen = 1'b1;
    end
    checkVal("abort_no_rsp", 32'(seen), 0);
    checkVal("abort_reqready", 32'(Req_Ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
